// File: rtl/wb_arb_mux.sv
// rtl/wb_arb_mux.sv - registered N:1 write-back result selector with round-robin arbitration
// Define WB_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module wb_arb_mux #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*SIZE-1:0]   in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [SIZE-1:0]          out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SIZE-1:0]   r_data;
  logic [SEL_W-1:0]  r_sel;
  logic              r_valid;

  logic [NUM_IN-1:0] w_grant;
  logic [SEL_W-1:0]  w_idx;
  logic              w_any;
  logic              w_load;
  logic              w_xfer;

`ifdef WB_ARB_MUX_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_any && in_valid[k]) begin
        w_any      = 1'b1;
        w_grant[k] = 1'b1;
        w_idx      = SEL_W'(k);
      end
    end
  end
`else
  logic [SEL_W-1:0] r_ptr;

  // Search starts at r_ptr and wraps modulo NUM_IN, so non-power-of-two sizes stay in range.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_any && in_valid[(int'(r_ptr) + k) % NUM_IN]) begin
        w_any                                  = 1'b1;
        w_grant[(int'(r_ptr) + k) % NUM_IN]    = 1'b1;
        w_idx                                  = SEL_W'((int'(r_ptr) + k) % NUM_IN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_idx + SEL_W'(1);
    end
  end
`endif

  assign w_load   = ~r_valid | out_ready;
  assign w_xfer   = w_any & w_load & ~rst;
  assign in_ready = rst ? '0 : (w_grant & {NUM_IN{w_load}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_idx*SIZE +: SIZE];
      r_sel   <= w_idx;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_wb_arb_mux.sv
// tb/tb_wb_arb_mux.sv - directed vector table plus randomized model check for wb_arb_mux
module tb_wb_arb_mux;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic [31:0]  ch_data [4];

  int tests;
  int fails;

  // reference state: what the output register should hold, and the next channel to favour
  logic         m_valid;
  logic [31:0]  m_data;
  int           m_sel;
  int           m_ptr;

  wb_arb_mux #(.SIZE(32), .NUM_IN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = ch_data[i];
  end

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic        ordy;
    logic [31:0] d2;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [1:0]  e_sel;
    logic [31:0] e_data;
  } vec_t;

  vec_t tab [21];

  function automatic vec_t mk(logic r, logic [3:0] v, logic ordy, logic [31:0] d2,
                              logic [3:0] e_rdy, logic e_val, logic [1:0] e_sel, logic [31:0] e_data);
    vec_t t;
    t.r = r; t.v = v; t.ordy = ordy; t.d2 = d2;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_sel = e_sel; t.e_data = e_data;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int m_grant(logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_MUX_FIXED_PRIO_EN
      if (v[k]) return k;
`else
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`endif
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready(logic r, logic [3:0] v, logic ordy);
    int g;
    g = m_grant(v);
    if (r || g < 0 || !(!m_valid || ordy)) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic m_step(logic r, logic [3:0] v, logic ordy);
    int g;
    g = m_grant(v);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (g >= 0 && (!m_valid || ordy)) begin
      m_valid = 1'b1; m_data = ch_data[g]; m_sel = g; m_ptr = (g + 1) % 4;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic set_default_data();
    for (int i = 0; i < 4; i++) ch_data[i] = 32'h100 + 32'(i);
  endtask

  initial begin
    tests = 0; fails = 0;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
    set_default_data();

`ifndef WB_ARB_MUX_FIXED_PRIO_EN
    tab[0]  = mk(1, 4'b1111, 1, 32'h102,      4'b0000, 0, 0, 32'h0);
    tab[1]  = mk(1, 4'b1111, 1, 32'h102,      4'b0000, 0, 0, 32'h0);
    tab[2]  = mk(0, 4'b0100, 1, 32'hDEADBEEF, 4'b0100, 1, 2, 32'hDEADBEEF);
    tab[3]  = mk(1, 4'b1111, 1, 32'h102,      4'b0000, 0, 0, 32'h0);
    tab[4]  = mk(0, 4'b1111, 1, 32'h102,      4'b0001, 1, 0, 32'h100);
    tab[5]  = mk(0, 4'b1111, 1, 32'h102,      4'b0010, 1, 1, 32'h101);
    tab[6]  = mk(0, 4'b1111, 1, 32'h102,      4'b0100, 1, 2, 32'h102);
    tab[7]  = mk(0, 4'b1111, 1, 32'h102,      4'b1000, 1, 3, 32'h103);
    tab[8]  = mk(0, 4'b1111, 1, 32'h102,      4'b0001, 1, 0, 32'h100);
    tab[9]  = mk(0, 4'b1111, 1, 32'h102,      4'b0010, 1, 1, 32'h101);
    tab[10] = mk(0, 4'b1010, 0, 32'h102,      4'b0000, 1, 1, 32'h101);
    tab[11] = mk(0, 4'b1010, 0, 32'h102,      4'b0000, 1, 1, 32'h101);
    tab[12] = mk(0, 4'b1010, 0, 32'h102,      4'b0000, 1, 1, 32'h101);
    tab[13] = mk(0, 4'b1010, 1, 32'h102,      4'b1000, 1, 3, 32'h103);
    tab[14] = mk(0, 4'b0100, 1, 32'h102,      4'b0100, 1, 2, 32'h102);
    tab[15] = mk(0, 4'b0011, 1, 32'h102,      4'b0001, 1, 0, 32'h100);
    tab[16] = mk(0, 4'b0011, 1, 32'h102,      4'b0010, 1, 1, 32'h101);
    tab[17] = mk(0, 4'b0000, 1, 32'h102,      4'b0000, 0, 1, 32'h101);
    tab[18] = mk(0, 4'b0000, 0, 32'h102,      4'b0000, 0, 1, 32'h101);
    tab[19] = mk(0, 4'b0100, 0, 32'h102,      4'b0100, 1, 2, 32'h102);
    tab[20] = mk(0, 4'b1000, 0, 32'h102,      4'b0000, 1, 2, 32'h102);

    @(posedge clk); #1;
    for (int n = 0; n < 21; n++) begin
      rst = tab[n].r; in_valid = tab[n].v; out_ready = tab[n].ordy;
      set_default_data();
      ch_data[2] = tab[n].d2;
      #4;
      chk($sformatf("vec%0d in_ready", n), 32'(in_ready), 32'(tab[n].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(tab[n].e_val));
      chk($sformatf("vec%0d out_sel", n), 32'(out_sel), 32'(tab[n].e_sel));
      chk($sformatf("vec%0d out_data", n), out_data, tab[n].e_data);
    end
`else
    // fixed priority: every channel requesting, channel 0 must win every cycle
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      #4;
      chk($sformatf("fixed%0d in_ready", n), 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("fixed%0d out_sel", n), 32'(out_sel), 32'h0);
      chk($sformatf("fixed%0d out_valid", n), 32'(out_valid), 32'h1);
    end
`endif

    // randomized run from a fresh reset against the reference model
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    m_step(1'b1, in_valid, out_ready);
    @(posedge clk); #1;
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] exp_rdy;
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) ch_data[i] = $urandom;
      #4;
      exp_rdy = m_ready(rst, in_valid, out_ready);
      chk($sformatf("rnd%0d in_ready", n), 32'(in_ready), 32'(exp_rdy));
      m_step(rst, in_valid, out_ready);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk($sformatf("rnd%0d out_sel", n), 32'(out_sel), 32'(m_sel));
        chk($sformatf("rnd%0d out_data", n), out_data, m_data);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arb_mux.md
# wb_arb_mux

Parametrised, registered N:1 result selector with valid/ready handshakes and round-robin arbitration. It sits at the write-back stage of the RISC-V core and merges results from several producers (ALU, load unit, mul/div, CSR) onto the single register-file write port. Unlike a plain combinational select mux, it chooses its own source by fairness, holds its output under back-pressure and reports which channel won.

## Interface
- `SIZE`, 32, data width per channel.
- `NUM_IN`, 4, number of input channels, ≥2.
- `SEL_W`, `$clog2(NUM_IN)`, width of the channel index.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  NUM_IN*SIZE  packed channel data; channel i occupies `[i*SIZE +: SIZE]`.
- `in_valid`  in  NUM_IN  per-channel request.
- `in_ready`  out  NUM_IN  per-channel accept, one-hot or zero.
- `out_data`  out  SIZE  registered selected data.
- `out_sel`  out  SEL_W  registered index of the channel that produced `out_data`.
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- Round-robin pointer `ptr` (SEL_W bits).
  - Each cycle, the grant goes to the first `i` with `in_valid[i]=1`, searching `ptr`, `ptr+1`, … mod NUM_IN.
  - `grant` is one-hot or zero.
- `load = ~out_valid | out_ready`: the output register is free or is being drained this cycle.
- `in_ready = grant & {NUM_IN{load}}`, combinational from `in_valid`, `ptr`, `out_valid` and `out_ready`.
  - Producers must not make `in_valid` depend on `in_ready`.
- Transfer on channel i happens when `in_valid[i] & in_ready[i]`. At the next edge:
  - `out_data` ← channel i data.
  - `out_sel` ← i.
  - `out_valid` ← 1.
  - `ptr` ← (i+1) mod NUM_IN.
- Drain without refill (`out_valid & out_ready`, no grant): `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- Stall (`out_valid & ~out_ready`):
  - `out_data`, `out_sel`, `out_valid` and `ptr` are held.
  - `in_ready` is all zero.
- Drain and refill in the same cycle: the new result is loaded, `out_valid` stays 1, and there is no bubble.
- Idle (no `in_valid`): `ptr` is unchanged.
- Wrap-around: `ptr` after a grant to NUM_IN-1 is 0.
- Non-power-of-two NUM_IN: `ptr` never exceeds NUM_IN-1.

## Timing
- Latency: 1 cycle from an accepted input to `out_valid`/`out_data`.
- Throughput: 1 result per cycle while `out_ready=1`.
- Reset, applied at the clock edge while `rst=1`:
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - `in_ready`=0 during reset regardless of `in_valid`.
- Reset mid-operation discards any held result. The first grant after reset searches from channel 0.
- `out_data`/`out_sel` are stable whenever `out_valid=1` and `out_ready=0`.

## Configuration
- `WB_ARB_MUX_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest-index valid channel always wins.
  - `ptr` logic is compiled out.
  - Used for configurations where the load unit must never be starved by ordering.
- Not defined: round-robin as described above.
- Handshake, latency and reset behaviour are identical in both modes.

## Test plan
- Reset:
  - Stimulus: hold `rst=1` for 2 cycles with `in_valid=4'b1111`.
  - Required: `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0`.
- Single request:
  - Stimulus: `in_valid=4'b0100`, channel 2 = 32'hDEADBEEF, `out_ready=1`.
  - Required: `in_ready=4'b0100` in the same cycle; next cycle `out_valid=1`, `out_data=32'hDEADBEEF`, `out_sel=2`.
- Fairness:
  - Stimulus: all four channels valid continuously from reset, `out_ready=1`, channel i data = i+32'h100.
  - Required: `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Back-pressure:
  - Stimulus: result from channel 1 loaded, then `out_ready=0` for 3 cycles while channels 1 and 3 are valid.
  - Required: `out_data`/`out_sel=1` held, `in_ready=0`.
  - Then: on `out_ready=1`, channel 3 is granted and `out_sel=3` on the next cycle.
- Skip and wrap:
  - Stimulus: `ptr=3` (after a channel-2 grant), `in_valid=4'b0011`.
  - Required: channel 0 is granted, then `ptr=1`.
- Macro and mid-operation reset:
  - Stimulus: with `WB_ARB_MUX_FIXED_PRIO_EN`, all channels valid.
  - Required: `out_sel` always 0.
  - Stimulus: `rst` pulse while `out_valid=1`.
  - Required: `out_valid=0` on the next cycle.
